// File: rtl/imm_pkg.sv
// Shared definitions for the immediate generator: format codes, RV opcodes,
// FIFO depth and the XLEN legality check.
package imm_pkg;

    // Resolved immediate format; the numeric values are visible on out_fmt.
    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_Z   = 3'd6,
        FMT_RSV = 3'd7
    } imm_fmt_e;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] FIFO_DEPTH = 2'd2;

    // Only RV32 and RV64 immediate widths are supported.
    function automatic bit xlen_legal(int unsigned xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/imm_fmt_decode.sv
// Combinational format resolution: opcode-driven when AUTO_DECODE is set,
// otherwise taken from the explicit selector. Illegal encodings resolve to R.
module imm_fmt_decode
    import imm_pkg::*;
#(
    parameter int unsigned AUTO_DECODE = 1
) (
    input  logic [31:0] inst_i,
    input  logic [2:0]  fmt_sel_i,
    output imm_fmt_e    fmt_o,
    output logic        illegal_o
);

    imm_fmt_e fmt;
    logic     illegal;

    // Map opcode (or selector) to a format, then force R on any illegal case.
    always_comb begin
        fmt     = FMT_R;
        illegal = 1'b0;
        if (AUTO_DECODE != 0) begin
            case (inst_i[6:0])
                OP_IMM, OP_LOAD, OP_JALR, OP_IMM32: fmt = FMT_I;
                OP_STORE:                           fmt = FMT_S;
                OP_BRANCH:                          fmt = FMT_B;
                OP_LUI, OP_AUIPC:                   fmt = FMT_U;
                OP_JAL:                             fmt = FMT_J;
                OP_REG, OP_REG32:                   fmt = FMT_R;
                OP_SYSTEM:                          fmt = inst_i[14] ? FMT_Z : FMT_I;
                default:                            illegal = 1'b1;
            endcase
        end else begin
            if (fmt_sel_i == FMT_RSV) begin
                illegal = 1'b1;
            end else begin
                fmt = imm_fmt_e'(fmt_sel_i);
            end
        end
        if (inst_i[1:0] != 2'b11) begin
            illegal = 1'b1;
        end
        if (illegal) begin
            fmt = FMT_R;
        end
        fmt_o     = fmt;
        illegal_o = illegal;
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decodes the format, extends the immediate to
// XLEN and queues results in a 2-entry FIFO with valid/ready on both sides.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned AUTO_DECODE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [2:0]      in_fmt_sel,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    imm_fmt_e        dec_fmt;
    logic            dec_illegal;
    logic [XLEN-1:0] imm_ext;

    imm_fmt_decode #(
        .AUTO_DECODE(AUTO_DECODE)
    ) u_decode (
        .inst_i    (in_inst),
        .fmt_sel_i (in_fmt_sel),
        .fmt_o     (dec_fmt),
        .illegal_o (dec_illegal)
    );

    // Assemble the immediate fields; signed casts sign-extend to XLEN.
    always_comb begin
        imm_ext = '0;
        case (dec_fmt)
            FMT_I: imm_ext = XLEN'($signed(in_inst[31:20]));
            FMT_S: imm_ext = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
            FMT_B: imm_ext = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                            in_inst[11:8], 1'b0}));
            FMT_U: imm_ext = XLEN'($signed({in_inst[31:12], 12'b0}));
            FMT_J: imm_ext = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                            in_inst[30:21], 1'b0}));
            FMT_Z: imm_ext = XLEN'(in_inst[19:15]);
            default: imm_ext = '0;
        endcase
    end

    logic [XLEN-1:0] imm_q [2];
    imm_fmt_e        fmt_q [2];
    logic            ill_q [2];
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic [1:0]      count_q, count_d;
    logic            push, pop;

    // in_ready depends only on the registered count (and reset), never on out_ready.
    assign in_ready  = !rst && (count_q < FIFO_DEPTH);
    assign out_valid = !rst && (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_imm     = out_valid ? imm_q[rd_ptr_q] : '0;
    assign out_fmt     = out_valid ? fmt_q[rd_ptr_q] : FMT_R;
    assign out_illegal = out_valid ? ill_q[rd_ptr_q] : 1'b0;

    // Next pointers and occupancy; 1-bit pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // FIFO control state with synchronous reset discarding all entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care until counted, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            imm_q[wr_ptr_q] <= imm_ext;
            fmt_q[wr_ptr_q] <= dec_fmt;
            ill_q[wr_ptr_q] <= dec_illegal;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench: three instances (RV32 auto, RV64 auto, RV32 explicit
// format) share stimulus; a queue-based reference model predicts all outputs.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_inst;
    logic [2:0]  in_fmt_sel;

    logic        rdy32, rdy64, rdym;
    logic        ov32, ov64, ovm;
    logic [31:0] imm32, immm;
    logic [63:0] imm64;
    logic [2:0]  f32, f64, fm;
    logic        il32, il64, ilm;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } res_t;

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  sel;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        bit          man_same;
    } vec_t;

    res_t q32[$];
    res_t q64[$];
    res_t qm[$];

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32),
        .in_inst(in_inst), .in_fmt_sel(in_fmt_sel), .out_valid(ov32),
        .out_ready(out_ready), .out_imm(imm32), .out_fmt(f32), .out_illegal(il32)
    );

    imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(1)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy64),
        .in_inst(in_inst), .in_fmt_sel(in_fmt_sel), .out_valid(ov64),
        .out_ready(out_ready), .out_imm(imm64), .out_fmt(f64), .out_illegal(il64)
    );

    imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(0)) dutm (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdym),
        .in_inst(in_inst), .in_fmt_sel(in_fmt_sel), .out_valid(ovm),
        .out_ready(out_ready), .out_imm(immm), .out_fmt(fm), .out_illegal(ilm)
    );

    function automatic longint sx(longint v, int bits);
        if (v >= (longint'(1) << (bits - 1))) return v - (longint'(1) << bits);
        return v;
    endfunction

    // Reference: field values assembled with plain arithmetic from the ISA rules.
    function automatic res_t ref_model(logic [31:0] inst, bit auto_dec,
                                       logic [2:0] sel, int xlen);
        res_t        r;
        int          fmt = 0;
        bit          ill = 0;
        longint      v   = 0;
        logic [6:0]  op  = inst[6:0];
        if (auto_dec) begin
            case (op)
                7'b0010011, 7'b0000011, 7'b1100111, 7'b0011011: fmt = 1;
                7'b0100011: fmt = 2;
                7'b1100011: fmt = 3;
                7'b0110111, 7'b0010111: fmt = 4;
                7'b1101111: fmt = 5;
                7'b0110011, 7'b0111011: fmt = 0;
                7'b1110011: fmt = inst[14] ? 6 : 1;
                default: ill = 1;
            endcase
        end else begin
            fmt = int'(sel);
            ill = (sel == 3'd7);
        end
        if (inst[1:0] != 2'b11) ill = 1;
        if (ill) fmt = 0;
        case (fmt)
            1: v = sx(longint'(inst[31:20]), 12);
            2: v = sx(longint'(inst[31:25]) * 32 + longint'(inst[11:7]), 12);
            3: v = sx(longint'(inst[31]) * 4096 + longint'(inst[7]) * 2048 +
                      longint'(inst[30:25]) * 32 + longint'(inst[11:8]) * 2, 13);
            4: v = sx(longint'(inst[31:12]), 20) * 4096;
            5: v = sx(longint'(inst[31]) * 1048576 + longint'(inst[19:12]) * 4096 +
                      longint'(inst[20]) * 2048 + longint'(inst[30:21]) * 2, 21);
            6: v = longint'(inst[19:15]);
            default: v = 0;
        endcase
        r.imm = (xlen == 32) ? {32'h0, v[31:0]} : v;
        r.fmt = 3'(fmt);
        r.ill = ill;
        return r;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        bit   ev;
        bit   er;
        res_t z;
        z.imm = '0; z.fmt = '0; z.ill = 1'b0;
        er = !rst && (q32.size() < 2);
        ev = !rst && (q32.size() > 0);
        chk("in_ready32", 64'(rdy32), 64'(er));
        chk("in_ready64", 64'(rdy64), 64'(er));
        chk("in_readym", 64'(rdym), 64'(er));
        chk("out_valid32", 64'(ov32), 64'(ev));
        chk("out_valid64", 64'(ov64), 64'(ev));
        chk("out_validm", 64'(ovm), 64'(ev));
        if (ev || rst) begin
            res_t e32, e64, em;
            e32 = ev ? q32[0] : z;
            e64 = ev ? q64[0] : z;
            em  = ev ? qm[0]  : z;
            chk("imm32", 64'(imm32), e32.imm);
            chk("fmt32", 64'(f32), 64'(e32.fmt));
            chk("ill32", 64'(il32), 64'(e32.ill));
            chk("imm64", imm64, e64.imm);
            chk("fmt64", 64'(f64), 64'(e64.fmt));
            chk("ill64", 64'(il64), 64'(e64.ill));
            chk("immm", 64'(immm), em.imm);
            chk("fmtm", 64'(fm), 64'(em.fmt));
            chk("illm", 64'(ilm), 64'(em.ill));
        end
    endtask

    // One clock: decide transfers from the model's occupancy, advance, compare.
    task automatic cycle();
        bit push, pop;
        push = !rst && in_valid && (q32.size() < 2);
        pop  = !rst && out_ready && (q32.size() > 0);
        @(posedge clk);
        #1;
        if (rst) begin
            q32.delete(); q64.delete(); qm.delete();
        end else begin
            if (pop) begin
                void'(q32.pop_front()); void'(q64.pop_front()); void'(qm.pop_front());
            end
            if (push) begin
                q32.push_back(ref_model(in_inst, 1'b1, in_fmt_sel, 32));
                q64.push_back(ref_model(in_inst, 1'b1, in_fmt_sel, 64));
                qm.push_back(ref_model(in_inst, 1'b0, in_fmt_sel, 32));
            end
        end
        check_outputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[10];
        logic [6:0] ops[12];

        vecs[0] = '{32'hFFF00093, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0, 1'b1};
        vecs[1] = '{32'h00112623, 3'd2, 64'h0000_0000_0000_000C, 3'd2, 1'b0, 1'b1};
        vecs[2] = '{32'hFE000EE3, 3'd3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0, 1'b1};
        vecs[3] = '{32'h0080006F, 3'd5, 64'h0000_0000_0000_0008, 3'd5, 1'b0, 1'b1};
        vecs[4] = '{32'h800000B7, 3'd4, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0, 1'b1};
        vecs[5] = '{32'h0002D073, 3'd6, 64'h0000_0000_0000_0005, 3'd6, 1'b0, 1'b1};
        vecs[6] = '{32'h00000000, 3'd1, 64'h0,                   3'd0, 1'b1, 1'b1};
        vecs[7] = '{32'h002081B3, 3'd0, 64'h0,                   3'd0, 1'b0, 1'b1};
        vecs[8] = '{32'h34011073, 3'd1, 64'h0000_0000_0000_0340, 3'd1, 1'b0, 1'b1};
        vecs[9] = '{32'hFFF00093, 3'd7, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0, 1'b0};

        ops = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0011011, 7'b0100011, 7'b1100011,
                7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b0111011, 7'b1110011};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_inst = '0; in_fmt_sel = '0;
        cycle();
        cycle();
        rst = 1'b0;
        #1;
        check_outputs();

        // Directed vectors: one instruction at a time, result the next cycle.
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_inst = vecs[i].inst; in_fmt_sel = vecs[i].sel;
            cycle();
            in_valid = 1'b0;
            chk("vec_valid", 64'(ov32), 64'd1);
            chk("vec_imm32", 64'(imm32), {32'h0, vecs[i].imm[31:0]});
            chk("vec_fmt32", 64'(f32), 64'(vecs[i].fmt));
            chk("vec_ill32", 64'(il32), 64'(vecs[i].ill));
            chk("vec_imm64", imm64, vecs[i].imm);
            chk("vec_fmt64", 64'(f64), 64'(vecs[i].fmt));
            if (vecs[i].man_same) begin
                chk("vec_immm", 64'(immm), {32'h0, vecs[i].imm[31:0]});
                chk("vec_fmtm", 64'(fm), 64'(vecs[i].fmt));
                chk("vec_illm", 64'(ilm), 64'(vecs[i].ill));
            end else begin
                chk("vec_immm", 64'(immm), 64'h0);
                chk("vec_fmtm", 64'(fm), 64'h0);
                chk("vec_illm", 64'(ilm), 64'h1);
            end
            cycle();
        end

        // Backpressure: three offered with out_ready low, then drain in order.
        out_ready = 1'b0; in_valid = 1'b1; in_fmt_sel = 3'd1;
        in_inst = 32'h00100093; cycle();
        in_inst = 32'h00200093; cycle();
        in_inst = 32'h00300093; cycle();
        chk("bp_full_ready", 64'(rdy32), 64'd0);
        chk("bp_hold_imm", 64'(imm32), 64'd1);
        cycle();
        chk("bp_stable_imm", 64'(imm32), 64'd1);
        out_ready = 1'b1;
        cycle();
        chk("bp_ready_after_pop", 64'(rdy32), 64'd1);
        chk("bp_second", 64'(imm32), 64'd2);
        cycle();
        in_valid = 1'b0;
        chk("bp_third", 64'(imm32), 64'd3);
        chk("bp_third_valid", 64'(ov32), 64'd1);
        cycle();
        chk("bp_empty", 64'(ov32), 64'd0);

        // Reset with two entries held: nothing stale may reappear.
        out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h00500093;
        cycle();
        cycle();
        in_valid = 1'b0;
        rst = 1'b1;
        cycle();
        chk("rst_flush_valid", 64'(ov64), 64'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rst_release_ready", 64'(rdy32), 64'd1);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("rst_no_stale", 64'(ov32), 64'd0);
        end

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] w;
            w = $urandom;
            if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 11)];
            in_inst    = w;
            in_fmt_sel = 3'($urandom_range(0, 7));
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 2) != 0);
            rst        = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
